// File: rtl/paging_regs_if.sv
// Shared machine type plus the CPU bus interface used by the paging register file.
package paging_regs_pkg;
  typedef enum logic [1:0] {
    MACHINE_48   = 2'd0,
    MACHINE_S128 = 2'd1,
    MACHINE_PENT = 2'd2,
    MACHINE_S3   = 2'd3
  } machine_t;
endpackage

// CPU bus signals seen by the I/O port decoders.
interface paging_regs_if;
  logic [15:0] a;
  logic [7:0]  d;
  logic        iorq;
  logic        wr;
  logic        m1;

  modport master (output a, d, iorq, wr, m1);
  modport slave  (input  a, d, iorq, wr, m1);
endinterface

// File: rtl/paging_regs.sv
// Paging register file for ports 7FFD / 1FFD / DFFD feeding memcontrol.
// A registered, edge-detected I/O write strobe gives one event per OUT;
// decode depends on the machine type and all ports honour the 7FFD lock.
module paging_regs
  import paging_regs_pkg::*;
#(
  parameter bit DFFD_EN     = 1'b1,
  parameter bit EXT_7FFD_EN = 1'b1
) (
  input  logic               i_clk28,
  input  logic               i_rst,
  paging_regs_if.slave       bus,
  input  machine_t           i_machine,
  input  logic               i_magic_map,
  output logic [2:0]         o_rampage128,
  output logic               o_screenpage,
  output logic               o_rompage128,
  output logic               o_lock_7ffd,
  output logic [2:0]         o_port_1ffd,
  output logic [4:0]         o_port_dffd,
  output logic [2:0]         o_rampage_ext
);

  logic       r_wr_q, r_wr_q2;
  machine_t   r_machine_q;
  logic [7:0] r_7ffd;
  logic [2:0] r_1ffd;
  logic [4:0] r_dffd;

  logic w_evt, w_mchg, w_allow;
  logic w_sel_7ffd, w_sel_1ffd, w_sel_dffd;
  logic w_pent_q;

  // One event per IORQ write: rising edge of the registered strobe.
  assign w_evt   = r_wr_q && !r_wr_q2;
  assign w_mchg  = (i_machine != r_machine_q);
  assign w_allow = !r_7ffd[5] || i_magic_map;

  // Port decode per machine; Pentagon 7FFD is partial so 0x1FFD aliases onto it.
  always_comb begin
    w_sel_7ffd = 1'b0;
    w_sel_1ffd = 1'b0;
    w_sel_dffd = 1'b0;
    unique case (i_machine)
      MACHINE_PENT: begin
        w_sel_7ffd = !bus.a[15] && !bus.a[1];
        w_sel_dffd = DFFD_EN && (bus.a[15:12] == 4'b1101) && !bus.a[1];
      end
      MACHINE_S128: begin
        w_sel_7ffd = (bus.a[15:14] == 2'b01) && !bus.a[1];
      end
      MACHINE_S3: begin
        w_sel_7ffd = (bus.a[15:14] == 2'b01) && !bus.a[1];
        w_sel_1ffd = (bus.a[15:12] == 4'b0001) && !bus.a[1];
      end
      default: ;
    endcase
  end

  // Write strobe pipeline and machine tracking.
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_wr_q      <= 1'b0;
      r_wr_q2     <= 1'b0;
      r_machine_q <= MACHINE_48;
    end else begin
      r_wr_q      <= bus.iorq && bus.wr && !bus.m1;
      r_wr_q2     <= r_wr_q;
      r_machine_q <= i_machine;
    end
  end

  // Paging registers: cleared on reset or machine change, else updated by allowed writes.
  always_ff @(posedge i_clk28) begin
    if (i_rst || w_mchg) begin
      r_7ffd <= '0;
      r_1ffd <= '0;
      r_dffd <= '0;
    end else if (w_evt && w_allow) begin
      if (w_sel_7ffd) r_7ffd <= bus.d;
      if (w_sel_1ffd) r_1ffd <= bus.d[2:0];
      if (w_sel_dffd) r_dffd <= bus.d[4:0];
    end
  end

  assign w_pent_q = (r_machine_q == MACHINE_PENT);

  assign o_rampage128  = r_7ffd[2:0];
  assign o_screenpage  = r_7ffd[3];
  assign o_rompage128  = r_7ffd[4];
  assign o_lock_7ffd   = r_7ffd[5];
  assign o_port_1ffd   = r_1ffd;
  assign o_port_dffd   = r_dffd;
  assign o_rampage_ext = w_pent_q ? {r_dffd[0], (EXT_7FFD_EN ? r_7ffd[7:6] : 2'b00)} : 3'b000;

endmodule

// File: tb/tb_paging_regs.sv
// Scoreboard bench for paging_regs: expected page state is queued with each
// stimulus and compared once the DUT has had time to apply it.
module tb_paging_regs;
  import paging_regs_pkg::*;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       magic_map;
  machine_t   machine;
  logic [2:0] rampage128, port_1ffd, rampage_ext;
  logic       screenpage, rompage128, lock_7ffd;
  logic [4:0] port_dffd;

  int n_chk = 0;
  int n_bad = 0;

  // state = {ext[2:0], dffd[4:0], p1ffd[2:0], lock, rom, scr, ram[2:0]}
  logic [16:0] sb_q[$];

  paging_regs_if bus();

  paging_regs #(.DFFD_EN(1'b1), .EXT_7FFD_EN(1'b1)) dut (
    .i_clk28       (clk28),
    .i_rst         (rst),
    .bus           (bus),
    .i_machine     (machine),
    .i_magic_map   (magic_map),
    .o_rampage128  (rampage128),
    .o_screenpage  (screenpage),
    .o_rompage128  (rompage128),
    .o_lock_7ffd   (lock_7ffd),
    .o_port_1ffd   (port_1ffd),
    .o_port_dffd   (port_dffd),
    .o_rampage_ext (rampage_ext)
  );

  always #5 clk28 = ~clk28;

  function automatic logic [16:0] mk(input logic [2:0] ram, input logic scr, input logic rom,
                                     input logic lk, input logic [2:0] p1, input logic [4:0] pd,
                                     input logic [2:0] ext);
    return {ext, pd, p1, lk, rom, scr, ram};
  endfunction

  function automatic logic [16:0] cur();
    return {rampage_ext, port_dffd, port_1ffd, lock_7ffd, rompage128, screenpage, rampage128};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [16:0] e;
    if (sb_q.size() == 0) begin
      n_chk++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk(tag, cur(), e);
    end
  endtask

  task automatic do_reset(input machine_t m);
    @(negedge clk28);
    rst = 1'b1; machine = m; magic_map = 1'b0;
    bus.iorq = 1'b0; bus.wr = 1'b0; bus.m1 = 1'b0; bus.a = '0; bus.d = '0;
    repeat (2) @(negedge clk28);
    rst = 1'b0;
    repeat (3) @(negedge clk28);
  endtask

  // One OUT: strobe high for two cycles, sample half a cycle after the applying edge.
  task automatic do_out(input string tag, input logic [15:0] a, input logic [7:0] d,
                        input logic m1, input logic [16:0] exp);
    sb_q.push_back(exp);
    bus.a = a; bus.d = d; bus.iorq = 1'b1; bus.wr = 1'b1; bus.m1 = m1;
    repeat (2) @(negedge clk28);
    bus.iorq = 1'b0; bus.wr = 1'b0; bus.m1 = 1'b0;
    sb_check(tag);
    @(negedge clk28);
  endtask

  initial begin
    rst = 1'b1; machine = MACHINE_48; magic_map = 1'b0;
    bus.iorq = 1'b0; bus.wr = 1'b0; bus.m1 = 1'b0; bus.a = '0; bus.d = '0;

    // ---- S128 basic write and latency ----
    do_reset(MACHINE_S128);
    sb_q.push_back('0);
    sb_check("reset");
    sb_q.push_back('0);
    sb_q.push_back(mk(3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 3'd0));
    bus.a = 16'h7FFD; bus.d = 8'h17; bus.iorq = 1'b1; bus.wr = 1'b1;
    @(negedge clk28);
    sb_check("s128_lat1");
    @(negedge clk28);
    bus.iorq = 1'b0; bus.wr = 1'b0;
    sb_check("s128_7ffd_17");
    @(negedge clk28);
    do_out("s128_m1_ignored", 16'h7FFD, 8'h02, 1'b1, mk(3'd7, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 3'd0));

    // ---- S3 lock and magic bypass ----
    do_reset(MACHINE_S3);
    do_out("s3_lock_set", 16'h7FFD, 8'h20, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 3'd0));
    do_out("s3_7ffd_locked", 16'h7FFD, 8'h03, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 3'd0));
    do_out("s3_1ffd_locked", 16'h1FFD, 8'h04, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 3'd0));
    magic_map = 1'b1;
    do_out("magic_bypass", 16'h7FFD, 8'h05, 1'b0, mk(3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 3'd0));
    magic_map = 1'b0;
    do_out("after_magic", 16'h7FFD, 8'h02, 1'b0, mk(3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 3'd0));
    do_out("s3_1ffd", 16'h1FFD, 8'h04, 1'b0, mk(3'd2, 1'b0, 1'b0, 1'b0, 3'd4, 5'd0, 3'd0));

    // ---- Pentagon: partial 7FFD decode, DFFD, rampage_ext ----
    do_reset(MACHINE_PENT);
    do_out("pent_1ffd_alias", 16'h1FFD, 8'hC3, 1'b0, mk(3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 3'b011));
    do_out("pent_dffd", 16'hDFFD, 8'h11, 1'b0, mk(3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 5'h11, 3'b111));

    // ---- 48K: no decode ----
    do_reset(MACHINE_48);
    do_out("48k_no_decode", 16'h7FFD, 8'h07, 1'b0, '0);

    // ---- Long IORQ: a single event, data taken in the event cycle ----
    do_reset(MACHINE_S128);
    sb_q.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 3'd0));
    bus.a = 16'h7FFD; bus.d = 8'h01; bus.iorq = 1'b1; bus.wr = 1'b1;
    repeat (10) @(negedge clk28);
    bus.d = 8'h02;
    repeat (10) @(negedge clk28);
    sb_check("long_iorq");
    bus.iorq = 1'b0; bus.wr = 1'b0;
    @(negedge clk28);

    // ---- Machine switch clears everything, including the lock ----
    do_out("pre_switch", 16'h7FFD, 8'h3F, 1'b0, mk(3'd7, 1'b1, 1'b1, 1'b1, 3'd0, 5'd0, 3'd0));
    sb_q.push_back('0);
    machine = MACHINE_PENT;
    @(negedge clk28);
    sb_check("switch_clear");
    repeat (2) @(negedge clk28);

    // Write whose event cycle coincides with a switch back to S128 is dropped.
    sb_q.push_back('0);
    bus.a = 16'h7FFD; bus.d = 8'h07; bus.iorq = 1'b1; bus.wr = 1'b1;
    @(negedge clk28);
    machine = MACHINE_S128;
    @(negedge clk28);
    bus.iorq = 1'b0; bus.wr = 1'b0;
    sb_check("switch_drop");
    repeat (2) @(negedge clk28);
    do_out("post_switch", 16'h7FFD, 8'h06, 1'b0, mk(3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 3'd0));

    if (sb_q.size() != 0) begin
      n_chk++; n_bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
